serv_imm_sequencer: RTL and testbench
=====================================

Name: serv_imm_sequencer

Overview:
- Control block that sequences the bit-serial immediate decoder (serv_immdec) for one instruction at a time.
- Accepts a 32-bit instruction over a valid/ready handshake and decodes the format from the opcode.
- Issues a one-cycle instruction load (wb_en/wb_rdt), then runs a 2^CNT_W-cycle bit-serial count with cnt_en/cnt_done, per-format immdec_en/ctrl and csr_imm_en. Stallable.
- Sits between the fetch interface and serv_immdec in the CPU core.

Parameters:
- CNT_W, 5: width of bit counter; run length = 2^CNT_W enabled cycles (32).
- STALL_EN, 1: 1 = i_stall gates counting; 0 = i_stall ignored.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_instr_valid  in  1  instruction offered
- o_instr_ready  out  1  sequencer can accept (IDLE)
- i_instr  in  32  instruction word
- i_stall  in  1  pause serial count
- o_wb_en  out  1  load pulse to decoder
- o_wb_rdt  out  25  latched i_instr[31:7]
- o_cnt_en  out  1  serial bit enable
- o_cnt  out  CNT_W  current bit index
- o_cnt_done  out  1  last bit of run
- o_immdec_en  out  4  per-format field shift enables
- o_ctrl  out  4  {is_u, is_j, is_b, is_s}
- o_csr_imm_en  out  1  CSR immediate select
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle completion pulse
- o_illegal  out  1  valid with o_done when opcode unrecognised

Behaviour:
- Reset (async, i_rst_n=0, any state): state=IDLE, counter=0, latched instr=0. All outputs 0 except o_instr_ready=1. Reset mid-run aborts immediately with no done pulse.
- States: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE: o_instr_ready=1. On i_instr_valid&ready, latch i_instr and the decoded format, then go to LOAD. Valid in any other state is ignored and the word is not consumed.
- LOAD: exactly one cycle. o_wb_en=1, o_wb_rdt=latched[31:7]. i_stall ignored. Next state RUN, counter=0.
- RUN:
  - o_cnt_en = ~(i_stall & STALL_EN).
  - Counter increments only when cnt_en=1.
  - o_cnt_done = cnt_en & (counter==all-ones).
  - On cnt_done go to DONE; the counter wraps to 0.
  - A stall on the last bit delays cnt_done, which is never asserted without cnt_en.
- DONE: one cycle. o_done=1, o_illegal per latched format. Next state IDLE.
- o_immdec_en, o_ctrl and o_csr_imm_en are registered from the latched format. They are held constant in LOAD, RUN and DONE, and are 0 in IDLE.
- Latency, no stall: accept at cycle N; wb_en at N+1; cnt_en N+2..N+33; cnt_done at N+33; done at N+34; ready at N+35. Each stall cycle adds 1.
- Format decode (opcode = instr[6:2]):
  - 00100/00000/11001 -> I: immdec_en=0011, ctrl=0000
  - 01000 -> S: 0101, ctrl=0001
  - 11000 -> B: 1101, ctrl=0010
  - 01101/00101 -> U: 1000, ctrl=1000
  - 11011 -> J: 1110, ctrl=0100
  - 01100 -> R: 0000, ctrl=0000
  - 11100 -> SYSTEM: 0000, ctrl=0000, csr_imm_en=instr[14]
  - instr[1:0]!=11 or any other opcode -> illegal: 0000, ctrl=0000, full sequence still runs, o_illegal=1 with done.
- csr_imm_en=0 for every non-SYSTEM format.

Decomposition:
- Package serv_imm_pkg holds:
  - state enum (IDLE, LOAD, RUN, DONE)
  - opcode constants
  - format enum (I, S, B, U, J, R, SYS, ILL)
  - immdec_en/ctrl mask constants
- Sub-module serv_imm_fmt_dec: purely combinational, opcode/funct3 -> format, immdec_en, ctrl, csr_imm_en, illegal.

Test Plan:
- Reset, then accept instr 0x00A00093 (ADDI) with no stall -> wb_en at N+1 with wb_rdt=0x0014001; immdec_en=0011; 32 cnt_en cycles; cnt_done at N+33; done at N+34; ready at N+35.
- Accept 0xFE0008E3 (B-type) and hold i_stall for 3 cycles at counter=31 -> cnt_done delayed to N+36; immdec_en=1101; ctrl=0010.
- Accept 0x30545073 (csrrwi) -> csr_imm_en=1, immdec_en=0000. Then 0x30501073 (csrrw) -> csr_imm_en=0.
- Accept 0xFFFFFFFF -> full 32-cycle run, o_illegal=1 coincident with o_done.
- Deassert i_rst_n asynchronously at counter=12 -> all outputs 0 and ready=1 with no clock edge needed. After release, a new accept starts from counter=0.
- Hold i_instr_valid high continuously -> back-to-back instructions accepted only in IDLE. With no stalls, the second accept is exactly 35 cycles after the first, and wb_en never overlaps cnt_en.

Source files
------------

// File: rtl/serv_imm_pkg.sv
// -----------------------------------------------------------------------------
// serv_imm_pkg
//   Shared types and constants for the serv immediate-decoder sequencer:
//   sequencer state encoding, RV32 major opcodes (instr[6:2]), instruction
//   format enumeration and the per-format immdec_en / ctrl masks that drive
//   serv_immdec.
// -----------------------------------------------------------------------------
package serv_imm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_U   = 3'd3,
    FMT_J   = 3'd4,
    FMT_R   = 3'd5,
    FMT_SYS = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  // Field shift enables into serv_immdec
  localparam logic [3:0] IMM_EN_I    = 4'b0011;
  localparam logic [3:0] IMM_EN_S    = 4'b0101;
  localparam logic [3:0] IMM_EN_B    = 4'b1101;
  localparam logic [3:0] IMM_EN_U    = 4'b1000;
  localparam logic [3:0] IMM_EN_J    = 4'b1110;
  localparam logic [3:0] IMM_EN_NONE = 4'b0000;

  // ctrl = {is_u, is_j, is_b, is_s}
  localparam logic [3:0] CTRL_S    = 4'b0001;
  localparam logic [3:0] CTRL_B    = 4'b0010;
  localparam logic [3:0] CTRL_J    = 4'b0100;
  localparam logic [3:0] CTRL_U    = 4'b1000;
  localparam logic [3:0] CTRL_NONE = 4'b0000;

  function automatic logic [3:0] fmt_immdec_en(input fmt_e f);
    logic [3:0] m;
    m = IMM_EN_NONE;
    case (f)
      FMT_I:   m = IMM_EN_I;
      FMT_S:   m = IMM_EN_S;
      FMT_B:   m = IMM_EN_B;
      FMT_U:   m = IMM_EN_U;
      FMT_J:   m = IMM_EN_J;
      default: m = IMM_EN_NONE;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] fmt_ctrl(input fmt_e f);
    logic [3:0] m;
    m = CTRL_NONE;
    case (f)
      FMT_S:   m = CTRL_S;
      FMT_B:   m = CTRL_B;
      FMT_U:   m = CTRL_U;
      FMT_J:   m = CTRL_J;
      default: m = CTRL_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/serv_imm_fmt_dec.sv
// -----------------------------------------------------------------------------
// serv_imm_fmt_dec
//   Combinational instruction-format decoder.
//   Ports:
//     quad_i       instr[1:0]; anything other than 2'b11 is not RV32 base
//     opcode_i     instr[6:2]
//     f3_imm_i     instr[14] (funct3[2]); selects the CSR immediate variants
//     immdec_en_o  per-format field shift enables
//     ctrl_o       {is_u, is_j, is_b, is_s}
//     csr_imm_en_o CSR immediate select (SYSTEM only)
//     illegal_o    opcode not recognised
// -----------------------------------------------------------------------------
module serv_imm_fmt_dec
  import serv_imm_pkg::*;
(
  input  logic [1:0] quad_i,
  input  logic [4:0] opcode_i,
  input  logic       f3_imm_i,
  output logic [3:0] immdec_en_o,
  output logic [3:0] ctrl_o,
  output logic       csr_imm_en_o,
  output logic       illegal_o
);

  fmt_e fmt;

  always_comb begin
    fmt = FMT_ILL;
    if (quad_i == 2'b11) begin
      case (opcode_i)
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
        OPC_STORE:                      fmt = FMT_S;
        OPC_BRANCH:                     fmt = FMT_B;
        OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
        OPC_JAL:                        fmt = FMT_J;
        OPC_OP:                         fmt = FMT_R;
        OPC_SYSTEM:                     fmt = FMT_SYS;
        default:                        fmt = FMT_ILL;
      endcase
    end
  end

  assign immdec_en_o  = fmt_immdec_en(fmt);
  assign ctrl_o       = fmt_ctrl(fmt);
  assign csr_imm_en_o = (fmt == FMT_SYS) & f3_imm_i;
  assign illegal_o    = (fmt == FMT_ILL);

endmodule

// File: rtl/serv_imm_sequencer.sv
// -----------------------------------------------------------------------------
// serv_imm_sequencer
//   Sequences serv_immdec for one instruction at a time:
//   IDLE (accept) -> LOAD (one wb_en pulse) -> RUN (2^CNT_W enabled bit
//   cycles, stallable) -> DONE (one-cycle done/illegal pulse) -> IDLE.
//   Ports:
//     i_clk, i_rst_n          clock, async active-low reset
//     i_instr_valid/i_instr   instruction offer; o_instr_ready high in IDLE
//     i_stall                 pauses the serial count (when STALL_EN)
//     o_wb_en/o_wb_rdt        decoder load pulse and latched instr[31:7]
//     o_cnt_en/o_cnt          serial bit enable and current bit index
//     o_cnt_done              last enabled bit of the run
//     o_immdec_en/o_ctrl      per-format decoder controls (0 in IDLE)
//     o_csr_imm_en            CSR immediate select
//     o_busy/o_done/o_illegal status
// -----------------------------------------------------------------------------
module serv_imm_sequencer
  import serv_imm_pkg::*;
#(
  parameter int CNT_W    = 5,
  parameter bit STALL_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_instr_valid,
  output logic             o_instr_ready,
  input  logic [31:0]      i_instr,
  input  logic             i_stall,
  output logic             o_wb_en,
  output logic [24:0]      o_wb_rdt,
  output logic             o_cnt_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_cnt_done,
  output logic [3:0]       o_immdec_en,
  output logic [3:0]       o_ctrl,
  output logic             o_csr_imm_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_illegal
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [24:0]      wb_rdt_q, wb_rdt_d;
  logic [3:0]       immdec_en_q, immdec_en_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             csr_imm_en_q, csr_imm_en_d;
  logic             illegal_q, illegal_d;

  logic [3:0]       dec_immdec_en;
  logic [3:0]       dec_ctrl;
  logic             dec_csr_imm_en;
  logic             dec_illegal;

  logic             accept;
  logic             cnt_en;
  logic             cnt_done;

  serv_imm_fmt_dec u_fmt_dec (
    .quad_i       (i_instr[1:0]),
    .opcode_i     (i_instr[6:2]),
    .f3_imm_i     (i_instr[14]),
    .immdec_en_o  (dec_immdec_en),
    .ctrl_o       (dec_ctrl),
    .csr_imm_en_o (dec_csr_imm_en),
    .illegal_o    (dec_illegal)
  );

  assign accept   = (state_q == ST_IDLE) & i_instr_valid;
  // Stall only matters while running; LOAD always completes in one cycle.
  assign cnt_en   = (state_q == ST_RUN) & ~(i_stall & STALL_EN);
  // Tied to cnt_en so a stall on the last bit holds off the done indication.
  assign cnt_done = cnt_en & (cnt_q == {CNT_W{1'b1}});

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wb_rdt_d     = wb_rdt_q;
    immdec_en_d  = immdec_en_q;
    ctrl_d       = ctrl_q;
    csr_imm_en_d = csr_imm_en_q;
    illegal_d    = illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_LOAD;
          wb_rdt_d     = i_instr[31:7];
          immdec_en_d  = dec_immdec_en;
          ctrl_d       = dec_ctrl;
          csr_imm_en_d = dec_csr_imm_en;
          illegal_d    = dec_illegal;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        if (cnt_en) begin
          // Natural wrap takes the counter back to 0 on the last bit.
          cnt_d = cnt_q + 1'b1;
          if (cnt_done) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        // Decoder controls read as zero whenever the sequencer is idle.
        immdec_en_d  = '0;
        ctrl_d       = '0;
        csr_imm_en_d = 1'b0;
        illegal_d    = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wb_rdt_q     <= '0;
      immdec_en_q  <= '0;
      ctrl_q       <= '0;
      csr_imm_en_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_rdt_q     <= wb_rdt_d;
      immdec_en_q  <= immdec_en_d;
      ctrl_q       <= ctrl_d;
      csr_imm_en_q <= csr_imm_en_d;
      illegal_q    <= illegal_d;
    end
  end

  assign o_instr_ready = (state_q == ST_IDLE);
  assign o_wb_en       = (state_q == ST_LOAD);
  assign o_wb_rdt      = wb_rdt_q;
  assign o_cnt_en      = cnt_en;
  assign o_cnt         = cnt_q;
  assign o_cnt_done    = cnt_done;
  assign o_immdec_en   = immdec_en_q;
  assign o_ctrl        = ctrl_q;
  assign o_csr_imm_en  = csr_imm_en_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = (state_q == ST_DONE);
  assign o_illegal     = (state_q == ST_DONE) & illegal_q;

endmodule

// File: tb/tb_serv_imm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_serv_imm_sequencer
//   Directed bench for serv_imm_sequencer with hand-computed expectations.
//   Cycle offsets are counted from the accepting cycle (offset 0).
// -----------------------------------------------------------------------------
module tb_serv_imm_sequencer;

  localparam int CNT_W = 5;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_instr_valid;
  logic             o_instr_ready;
  logic [31:0]      i_instr;
  logic             i_stall;
  logic             o_wb_en;
  logic [24:0]      o_wb_rdt;
  logic             o_cnt_en;
  logic [CNT_W-1:0] o_cnt;
  logic             o_cnt_done;
  logic [3:0]       o_immdec_en;
  logic [3:0]       o_ctrl;
  logic             o_csr_imm_en;
  logic             o_busy;
  logic             o_done;
  logic             o_illegal;

  serv_imm_sequencer #(.CNT_W(CNT_W), .STALL_EN(1'b1)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_instr_valid (i_instr_valid),
    .o_instr_ready (o_instr_ready),
    .i_instr       (i_instr),
    .i_stall       (i_stall),
    .o_wb_en       (o_wb_en),
    .o_wb_rdt      (o_wb_rdt),
    .o_cnt_en      (o_cnt_en),
    .o_cnt         (o_cnt),
    .o_cnt_done    (o_cnt_done),
    .o_immdec_en   (o_immdec_en),
    .o_ctrl        (o_ctrl),
    .o_csr_imm_en  (o_csr_imm_en),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_illegal     (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observations from the most recent run_instr
  int          wb_at, en_first, en_cnt, cnt_first, cdone_at, done_at, rdy_at;
  int          proto_bad, held_bad, ill_stray;
  logic        ill_at_done;
  logic [24:0] rdt_seen;
  logic [3:0]  imm_seen, ctrl_seen;
  logic        csr_seen;
  logic [8:0]  idle_bits;

  // Offer one instruction from IDLE and follow it until ready returns.
  // Stalls stall_n cycles once the bit counter reaches 31.
  task automatic run_instr(input logic [31:0] instr, input int stall_n);
    int k;
    int left;
    wb_at = -1; en_first = -1; en_cnt = 0; cnt_first = -1; cdone_at = -1;
    done_at = -1; rdy_at = -1; proto_bad = 0; held_bad = 0; ill_stray = 0;
    ill_at_done = 1'b0; rdt_seen = '0; imm_seen = '0; ctrl_seen = '0;
    csr_seen = 1'b0; idle_bits = '1;
    left = stall_n;
    i_instr = instr;
    i_instr_valid = 1'b1;
    #1;
    @(posedge i_clk); #1;
    i_instr_valid = 1'b0;
    i_instr = '0;
    k = 1;
    while (k < 100 && rdy_at < 0) begin
      i_stall = (left > 0) && o_busy && !o_wb_en && !o_done && (o_cnt == 5'd31);
      #1;
      if (o_wb_en && wb_at < 0) begin
        wb_at = k; rdt_seen = o_wb_rdt; imm_seen = o_immdec_en;
        ctrl_seen = o_ctrl; csr_seen = o_csr_imm_en;
      end
      if (wb_at >= 0 && o_busy &&
          ({o_immdec_en, o_ctrl, o_csr_imm_en} != {imm_seen, ctrl_seen, csr_seen}))
        held_bad++;
      if (o_cnt_en) begin
        if (en_first < 0) begin en_first = k; cnt_first = int'(o_cnt); end
        en_cnt++;
        if (o_wb_en) proto_bad++;
      end
      if (o_cnt_done) begin
        if (cdone_at < 0) cdone_at = k;
        if (!o_cnt_en) proto_bad++;
      end
      if (o_done && done_at < 0) begin done_at = k; ill_at_done = o_illegal; end
      if (o_illegal && !o_done) ill_stray++;
      if (o_instr_ready) begin
        rdy_at = k;
        idle_bits = {o_immdec_en, o_ctrl, o_csr_imm_en};
      end
      if (i_stall) left--;
      if (rdy_at < 0) begin
        @(posedge i_clk); #1;
        k++;
      end
    end
    i_stall = 1'b0;
  endtask

  task automatic expect_run(input string t, input int cd, input logic [24:0] rdt,
                            input logic [3:0] imm, input logic [3:0] ctrl,
                            input logic csr, input logic ill);
    check({t, "_wb_at"},     wb_at, 1);
    check({t, "_wb_rdt"},    rdt_seen, rdt);
    check({t, "_immdec_en"}, imm_seen, imm);
    check({t, "_ctrl"},      ctrl_seen, ctrl);
    check({t, "_csr_imm"},   csr_seen, csr);
    check({t, "_en_first"},  en_first, 2);
    check({t, "_cnt_first"}, cnt_first, 0);
    check({t, "_en_cnt"},    en_cnt, 32);
    check({t, "_cdone_at"},  cdone_at, cd);
    check({t, "_done_at"},   done_at, cd + 1);
    check({t, "_ready_at"},  rdy_at, cd + 2);
    check({t, "_illegal"},   ill_at_done, ill);
    check({t, "_ill_stray"}, ill_stray, 0);
    check({t, "_proto"},     proto_bad, 0);
    check({t, "_held"},      held_bad, 0);
    check({t, "_idle_zero"}, idle_bits, 0);
  endtask

  initial begin
    int k;
    int acc1, acc2, n_acc, bad;
    i_rst_n = 1'b0;
    i_instr_valid = 1'b0;
    i_instr = '0;
    i_stall = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_ready", o_instr_ready, 1);
    check("rst_outs", {o_wb_en, o_wb_rdt, o_cnt_en, o_cnt, o_cnt_done, o_immdec_en,
                       o_ctrl, o_csr_imm_en, o_busy, o_done, o_illegal}, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // ADDI x1, x0, 10
    run_instr(32'h00A00093, 0);
    expect_run("addi", 33, 25'h0014001, 4'b0011, 4'b0000, 1'b0, 1'b0);

    // BEQ-style branch, 3 stall cycles on the last bit
    run_instr(32'hFE0008E3, 3);
    expect_run("branch_stall", 36, 25'h1FC0011, 4'b1101, 4'b0010, 1'b0, 1'b0);

    // csrrwi / csrrw
    run_instr(32'h30545073, 0);
    expect_run("csrrwi", 33, 25'h060A8A0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    run_instr(32'h30501073, 0);
    expect_run("csrrw", 33, 25'h060A020, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Other formats
    run_instr(32'h123450B7, 0);
    expect_run("lui", 33, 25'h02468A1, 4'b1000, 4'b1000, 1'b0, 1'b0);
    run_instr(32'h008000EF, 0);
    expect_run("jal", 33, 25'h0010001, 4'b1110, 4'b0100, 1'b0, 1'b0);
    run_instr(32'h00112023, 0);
    expect_run("sw", 33, 25'h0002240, 4'b0101, 4'b0001, 1'b0, 1'b0);

    // Illegal opcode and illegal quadrant
    run_instr(32'hFFFFFFFF, 0);
    expect_run("ill_opc", 33, 25'h1FFFFFF, 4'b0000, 4'b0000, 1'b0, 1'b1);
    run_instr(32'h00A00091, 0);
    expect_run("ill_quad", 33, 25'h0014001, 4'b0000, 4'b0000, 1'b0, 1'b1);

    // Asynchronous reset mid-run at counter = 12
    i_instr = 32'h008000EF;
    i_instr_valid = 1'b1;
    #1;
    @(posedge i_clk); #1;
    i_instr_valid = 1'b0;
    k = 0;
    while (!(o_busy && !o_wb_en && o_cnt == 5'd12) && k < 50) begin
      @(posedge i_clk); #1;
      k++;
    end
    check("rst_reach12", o_cnt, 12);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_ready", o_instr_ready, 1);
    check("arst_outs", {o_wb_en, o_wb_rdt, o_cnt_en, o_cnt, o_cnt_done, o_immdec_en,
                        o_ctrl, o_csr_imm_en, o_busy, o_done, o_illegal}, 0);
    @(posedge i_clk); #3;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    run_instr(32'h00A00093, 0);
    expect_run("post_rst", 33, 25'h0014001, 4'b0011, 4'b0000, 1'b0, 1'b0);

    // Valid held high continuously: accepts only from IDLE, 35 cycles apart
    i_instr = 32'h00A00093;
    i_instr_valid = 1'b1;
    acc1 = -1; acc2 = -1; n_acc = 0; bad = 0;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (o_instr_ready) begin
        n_acc++;
        if (acc1 < 0) acc1 = c;
        else if (acc2 < 0) acc2 = c;
      end
      if (o_instr_ready == o_busy) bad++;
      if (o_wb_en && o_cnt_en) bad++;
      @(posedge i_clk); #1;
    end
    i_instr_valid = 1'b0;
    check("b2b_first", acc1, 0);
    check("b2b_second", acc2, 35);
    check("b2b_count", n_acc, 3);
    check("b2b_proto", bad, 0);
    k = 0;
    while (!o_instr_ready && k < 100) begin
      @(posedge i_clk); #1;
      k++;
    end
    check("b2b_drain", o_instr_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
